ffe_mac_engine: RTL

Parametrised, time-multiplexed FFE filter core with one multiplier and one accumulator.
- Accepts one sample per valid/ready handshake and shifts it into an NTAPS-deep delay line.
- Sweeps all taps through a pipelined MAC, then rounds and saturates the result.
- Holds the result on a valid/ready output.
- Tap coefficients are runtime-programmable, replacing fixed taps. Sits between the sample source and the slicer in the FFE subsystem.

---
 rtl/ffe_pkg.sv | 32 +++
 rtl/ffe_mac_engine_if.sv | 30 +++
 rtl/ffe_round_sat.sv | 34 +++
 rtl/ffe_mac_engine.sv | 118 +++++++++++
 4 files changed

// File: rtl/ffe_pkg.sv
// Shared types and constants for the FFE MAC engine: FSM states, accumulator
// sizing and the legacy power-on tap set.
package ffe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } ffe_state_t;

    localparam int RST_COEF_0 = 1024;
    localparam int RST_COEF_1 = -512;
    localparam int RST_COEF_2 = 320;
    localparam int RST_COEF_3 = -128;

    // Full-precision products plus enough headroom that NTAPS of them never overflow.
    function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned ntaps);
        return 2 * data_w + $clog2(ntaps);
    endfunction

    function automatic int rst_coef(input int k);
        case (k)
            0:       return RST_COEF_0;
            1:       return RST_COEF_1;
            2:       return RST_COEF_2;
            3:       return RST_COEF_3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/ffe_mac_engine_if.sv
// Sample, result and coefficient-write signals of the FFE MAC engine.
// master = sample source / controller side, slave = engine side.
interface ffe_mac_engine_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned NTAPS  = 4,
    parameter int unsigned TAP_AW = $clog2(NTAPS)
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;
    logic                     coef_wr_en;
    logic [TAP_AW-1:0]        coef_wr_addr;
    logic signed [DATA_W-1:0] coef_wr_data;
    logic                     coef_wr_ready;
    logic                     busy;

    modport master (
        output in_valid, in_data, out_ready, coef_wr_en, coef_wr_addr, coef_wr_data,
        input  in_ready, out_valid, out_data, out_sat, coef_wr_ready, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_wr_en, coef_wr_addr, coef_wr_data,
        output in_ready, out_valid, out_data, out_sat, coef_wr_ready, busy
    );
endinterface

// File: rtl/ffe_round_sat.sv
// Combinational round-half-up and saturate from the accumulator width down to
// the output sample width; o_sat_c flags a clamp.
module ffe_round_sat #(
    parameter int unsigned ACC_W  = 26,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned FRAC_W = 11
) (
    input  logic signed [ACC_W-1:0]  i_sum,
    output logic signed [DATA_W-1:0] o_value_c,
    output logic                     o_sat_c
);
    // One guard bit so adding the rounding constant can never wrap.
    localparam int unsigned EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] HALF  = EXT_W'(1) << (FRAC_W - 1);
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] MIN_V = -EXT_W'(2 ** (DATA_W - 1));

    logic signed [EXT_W-1:0] w_biased;
    logic signed [EXT_W-1:0] w_shifted;

    always_comb begin
        w_biased  = EXT_W'(i_sum) + HALF;
        w_shifted = w_biased >>> FRAC_W;
        o_value_c = DATA_W'(w_shifted);
        o_sat_c   = 1'b0;
        if (w_shifted > MAX_V) begin
            o_value_c = DATA_W'(MAX_V);
            o_sat_c   = 1'b1;
        end else if (w_shifted < MIN_V) begin
            o_value_c = DATA_W'(MIN_V);
            o_sat_c   = 1'b1;
        end
    end
endmodule

// File: rtl/ffe_mac_engine.sv
// Time-multiplexed FFE core: one multiplier sweeps NTAPS taps per sample, then
// the full-precision sum is rounded/saturated and held on a valid/ready output.
module ffe_mac_engine
    import ffe_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned NTAPS  = 4,
    parameter int unsigned FRAC_W = 11,
    parameter int unsigned ACC_W  = acc_width(DATA_W, NTAPS),
    parameter int unsigned TAP_AW = $clog2(NTAPS)
) (
    input  logic            ffe_clk,
    input  logic            rst,
    ffe_mac_engine_if.slave bus
);
    localparam int unsigned PROD_W = 2 * DATA_W;

    ffe_state_t               r_state;
    logic signed [DATA_W-1:0] r_x [NTAPS];
    logic signed [DATA_W-1:0] r_h [NTAPS];
    logic signed [PROD_W-1:0] r_prod;
    logic signed [ACC_W-1:0]  r_acc;
    logic [TAP_AW-1:0]        r_tap;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_out_sat;

    logic                     w_idle_rdy;
    logic                     w_coef_we;
    logic signed [PROD_W-1:0] w_h_ext;
    logic signed [PROD_W-1:0] w_x_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [DATA_W-1:0] w_rs_value;
    logic                     w_rs_sat;

    assign w_idle_rdy = (r_state == IDLE) && !rst;
    assign w_coef_we  = w_idle_rdy && bus.coef_wr_en && (32'(bus.coef_wr_addr) < NTAPS);

    // Pipelined MAC: r_prod lags the tap counter by one cycle, so FLUSH adds the last product.
    assign w_h_ext = PROD_W'(r_h[r_tap]);
    assign w_x_ext = PROD_W'(r_x[r_tap]);
    assign w_sum   = r_acc + ACC_W'(r_prod);

    ffe_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_round_sat (
        .i_sum     (w_sum),
        .o_value_c (w_rs_value),
        .o_sat_c   (w_rs_sat)
    );

    always_ff @(posedge ffe_clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prod      <= '0;
            r_acc       <= '0;
            r_tap       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                r_x[k] <= '0;
                r_h[k] <= DATA_W'(rst_coef(k));
            end
        end else begin
            // A write alongside an accepted sample lands before the first MAC cycle reads it.
            if (w_coef_we) begin
                r_h[bus.coef_wr_addr] <= bus.coef_wr_data;
            end
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x[0] <= bus.in_data;
                        for (int k = 1; k < NTAPS; k++) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_acc   <= '0;
                        r_prod  <= '0;
                        r_tap   <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_prod <= w_h_ext * w_x_ext;
                    r_acc  <= w_sum;
                    if (32'(r_tap) == NTAPS - 1) begin
                        r_tap   <= '0;
                        r_state <= FLUSH;
                    end else begin
                        r_tap <= r_tap + TAP_AW'(1);
                    end
                end
                FLUSH: begin
                    r_out_data  <= w_rs_value;
                    r_out_sat   <= w_rs_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = w_idle_rdy;
    assign bus.coef_wr_ready = w_idle_rdy;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.out_sat       = r_out_sat;
    assign bus.busy          = (r_state != IDLE);
endmodule
